// File: rtl/instr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_pkg : instruction word forwarded from decode to the PE array   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package instr_pkg;

  typedef struct packed {
    logic [5:0] opcode;
    logic [1:0] mode;
    logic [7:0] imm;
  } instruction_t;

  localparam int INSTR_WIDTH = $bits(instruction_t);

endpackage
`default_nettype wire

// File: rtl/nmcu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nmcu_pkg : shared widths and dispatch-sequencer state encoding       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package nmcu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 16;
  localparam int LEN_WIDTH  = 8;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    REQ_A   = 4'd1,
    RSP_A   = 4'd2,
    REQ_B   = 4'd3,
    RSP_B   = 4'd4,
    ISSUE   = 4'd5,
    WAIT_PE = 4'd6,
    WRITE   = 4'd7,
    FIN     = 4'd8
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/pe_dispatch_seq_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pe_seq_accum : dot-product accumulator, clear has priority over add  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pe_seq_accum #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_add,
  output logic [DATA_WIDTH-1:0] o_acc
);

  logic [DATA_WIDTH-1:0] r_acc;

  // Sum deliberately wraps at DATA_WIDTH bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + i_add;
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/pe_dispatch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pe_dispatch_seq : fetches A[i]/B[i], issues pairs to the PE array,   |
// | accumulates results and writes the dot product to C. Rev 1.0         |
// +----------------------------------------------------------------------+
module pe_dispatch_seq #(
  parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = nmcu_pkg::ADDR_WIDTH,
  parameter int LEN_WIDTH  = nmcu_pkg::LEN_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  instr_pkg::instruction_t  cmd_instr_i,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr_a_i,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr_b_i,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr_c_i,
  input  logic [LEN_WIDTH-1:0]     cmd_len_i,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]    mem_req_addr_o,
  input  logic                     mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]    mem_rsp_data_i,
  output logic                     pe_cmd_valid_o,
  input  logic                     pe_cmd_ready_i,
  output instr_pkg::instruction_t  pe_cmd_o,
  output logic [DATA_WIDTH-1:0]    pe_operand_a_o,
  output logic [DATA_WIDTH-1:0]    pe_operand_b_o,
  input  logic                     pe_done_i,
  input  logic [DATA_WIDTH-1:0]    pe_result_i,
  output logic                     wr_valid_o,
  input  logic                     wr_ready_i,
  output logic [ADDR_WIDTH-1:0]    wr_addr_o,
  output logic [DATA_WIDTH-1:0]    wr_data_o,
  output logic                     busy_o,
  output logic                     done_o
);

  import nmcu_pkg::*;

  seq_state_e               r_state;
  seq_state_e               w_state_nxt;
  instr_pkg::instruction_t  r_instr;
  logic [ADDR_WIDTH-1:0]    r_addr_a;
  logic [ADDR_WIDTH-1:0]    r_addr_b;
  logic [ADDR_WIDTH-1:0]    r_addr_c;
  logic [LEN_WIDTH-1:0]     r_len;
  logic [LEN_WIDTH-1:0]     r_idx;
  logic [DATA_WIDTH-1:0]    r_op_a;
  logic [DATA_WIDTH-1:0]    r_op_b;
  logic [DATA_WIDTH-1:0]    w_acc;
  logic [LEN_WIDTH:0]       w_idx_inc;
  logic [ADDR_WIDTH-1:0]    w_idx_addr;
  logic                     w_cmd_fire;
  logic                     w_pe_fire;
  logic                     w_last;

  assign w_cmd_fire = cmd_valid_i && (r_state == IDLE);
  assign w_pe_fire  = pe_done_i && (r_state == WAIT_PE);
  // One extra bit so N = all-ones still terminates.
  assign w_idx_inc  = {1'b0, r_idx} + (LEN_WIDTH+1)'(1);
  assign w_last     = (w_idx_inc == {1'b0, r_len});
  assign w_idx_addr = ADDR_WIDTH'(r_idx);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cmd_valid_i) w_state_nxt = (cmd_len_i == '0) ? WRITE : REQ_A;
      REQ_A:   if (mem_req_ready_i) w_state_nxt = RSP_A;
      RSP_A:   if (mem_rsp_valid_i) w_state_nxt = REQ_B;
      REQ_B:   if (mem_req_ready_i) w_state_nxt = RSP_B;
      RSP_B:   if (mem_rsp_valid_i) w_state_nxt = ISSUE;
      ISSUE:   if (pe_cmd_ready_i) w_state_nxt = WAIT_PE;
      WAIT_PE: if (pe_done_i) w_state_nxt = w_last ? WRITE : REQ_A;
      WRITE:   if (wr_ready_i) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr  <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_addr_c <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_instr  <= cmd_instr_i;
        r_addr_a <= cmd_addr_a_i;
        r_addr_b <= cmd_addr_b_i;
        r_addr_c <= cmd_addr_c_i;
        r_len    <= cmd_len_i;
        r_idx    <= '0;
      end
      if ((r_state == RSP_A) && mem_rsp_valid_i) r_op_a <= mem_rsp_data_i;
      if ((r_state == RSP_B) && mem_rsp_valid_i) r_op_b <= mem_rsp_data_i;
      if (w_pe_fire) r_idx <= w_idx_inc[LEN_WIDTH-1:0];
    end
  end

  pe_seq_accum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_cmd_fire),
    .i_en  (w_pe_fire),
    .i_add (pe_result_i),
    .o_acc (w_acc)
  );

  always_comb begin
    mem_req_addr_o = '0;
    if (r_state == REQ_A) mem_req_addr_o = r_addr_a + w_idx_addr;
    if (r_state == REQ_B) mem_req_addr_o = r_addr_b + w_idx_addr;
  end

  assign cmd_ready_o     = (r_state == IDLE);
  assign mem_req_valid_o = (r_state == REQ_A) || (r_state == REQ_B);
  assign pe_cmd_valid_o  = (r_state == ISSUE);
  assign pe_cmd_o        = r_instr;
  assign pe_operand_a_o  = r_op_a;
  assign pe_operand_b_o  = r_op_b;
  assign wr_valid_o      = (r_state == WRITE);
  assign wr_addr_o       = r_addr_c;
  assign wr_data_o       = w_acc;
  assign busy_o          = (r_state != IDLE);
  assign done_o          = (r_state == FIN);

endmodule
`default_nettype wire

// File: tb/tb_pe_dispatch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pe_dispatch_seq : directed bench with memory, PE and sink models  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pe_dispatch_seq;
  import instr_pkg::*;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid_i, cmd_ready_o;
  instruction_t cmd_instr_i, pe_cmd_o;
  logic [AW-1:0] cmd_addr_a_i, cmd_addr_b_i, cmd_addr_c_i;
  logic [LW-1:0] cmd_len_i;
  logic mem_req_valid_o, mem_req_ready_i, mem_rsp_valid_i;
  logic [AW-1:0] mem_req_addr_o;
  logic [DW-1:0] mem_rsp_data_i;
  logic pe_cmd_valid_o, pe_cmd_ready_i, pe_done_i;
  logic [DW-1:0] pe_operand_a_o, pe_operand_b_o, pe_result_i;
  logic wr_valid_o, wr_ready_i;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic busy_o, done_o;

  pe_dispatch_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_instr_i(cmd_instr_i),
    .cmd_addr_a_i(cmd_addr_a_i), .cmd_addr_b_i(cmd_addr_b_i), .cmd_addr_c_i(cmd_addr_c_i),
    .cmd_len_i(cmd_len_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i(mem_rsp_data_i),
    .pe_cmd_valid_o(pe_cmd_valid_o), .pe_cmd_ready_i(pe_cmd_ready_i), .pe_cmd_o(pe_cmd_o),
    .pe_operand_a_o(pe_operand_a_o), .pe_operand_b_o(pe_operand_b_o),
    .pe_done_i(pe_done_i), .pe_result_i(pe_result_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] mem [0:255];
  int  mem_lat = 1;
  int  pe_lat = 1;
  bit  stall_en = 1'b0;
  int  done_cnt = 0;

  logic [AW-1:0] rd_log[$];
  logic [15:0]   pe_cmd_log[$];
  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];

  // Memory model: one outstanding read, response mem_lat cycles after accept.
  int            mem_cnt = 0;
  logic [AW-1:0] mem_pend_addr;
  bit            mem_stalled = 1'b0;
  logic [AW-1:0] mem_stall_addr;
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_cnt = 0;
      mem_rsp_valid_i = 1'b0;
      mem_req_ready_i = 1'b0;
      mem_stalled = 1'b0;
    end else begin
      mem_rsp_valid_i = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_rsp_valid_i = 1'b1;
          mem_rsp_data_i = mem[mem_pend_addr[7:0]];
        end
      end
      if (mem_stalled) chk("mem_req_hold", {mem_req_valid_o, mem_req_addr_o}, {1'b1, mem_stall_addr});
      mem_req_ready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mem_req_valid_o && mem_req_ready_i) begin
        mem_pend_addr = mem_req_addr_o;
        mem_cnt = mem_lat;
        rd_log.push_back(mem_req_addr_o);
      end
      mem_stalled = mem_req_valid_o && !mem_req_ready_i;
      mem_stall_addr = mem_req_addr_o;
    end
  end

  // PE model: result = a*b (wrapping), pe_lat cycles after issue.
  int            pe_cnt = 0;
  logic [DW-1:0] pe_res;
  bit            pe_stalled = 1'b0;
  logic [DW-1:0] pe_sa, pe_sb;
  logic [15:0]   pe_sc;
  always @(negedge clk) begin
    if (!rst_n) begin
      pe_cnt = 0;
      pe_done_i = 1'b0;
      pe_cmd_ready_i = 1'b0;
      pe_stalled = 1'b0;
    end else begin
      pe_done_i = 1'b0;
      if (pe_cnt > 0) begin
        pe_cnt--;
        if (pe_cnt == 0) begin
          pe_done_i = 1'b1;
          pe_result_i = pe_res;
        end
      end
      if (pe_stalled) begin
        chk("pe_valid_hold", pe_cmd_valid_o, 1'b1);
        chk("pe_opa_hold", pe_operand_a_o, pe_sa);
        chk("pe_opb_hold", pe_operand_b_o, pe_sb);
        chk("pe_cmd_hold", pe_cmd_o, pe_sc);
      end
      pe_cmd_ready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pe_cmd_valid_o && pe_cmd_ready_i) begin
        pe_res = pe_operand_a_o * pe_operand_b_o;
        pe_cnt = pe_lat;
        pe_cmd_log.push_back(pe_cmd_o);
      end
      pe_stalled = pe_cmd_valid_o && !pe_cmd_ready_i;
      pe_sa = pe_operand_a_o;
      pe_sb = pe_operand_b_o;
      pe_sc = pe_cmd_o;
    end
  end

  // Write sink.
  bit            wr_stalled = 1'b0;
  logic [AW-1:0] wr_sa;
  logic [DW-1:0] wr_sd;
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_ready_i = 1'b0;
      wr_stalled = 1'b0;
    end else begin
      if (wr_stalled) begin
        chk("wr_valid_hold", wr_valid_o, 1'b1);
        chk("wr_addr_hold", wr_addr_o, wr_sa);
        chk("wr_data_hold", wr_data_o, wr_sd);
      end
      wr_ready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (wr_valid_o && wr_ready_i) begin
        wr_addr_log.push_back(wr_addr_o);
        wr_data_log.push_back(wr_data_o);
      end
      wr_stalled = wr_valid_o && !wr_ready_i;
      wr_sa = wr_addr_o;
      wr_sd = wr_data_o;
    end
  end

  always @(posedge clk) if (done_o) done_cnt++;

  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] c, input logic [LW-1:0] n,
                          input logic [15:0] ins, output int done_at_accept);
    int k;
    @(negedge clk);
    cmd_addr_a_i = a;
    cmd_addr_b_i = b;
    cmd_addr_c_i = c;
    cmd_len_i = n;
    cmd_instr_i = ins;
    cmd_valid_i = 1'b1;
    k = 0;
    while (!cmd_ready_o && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready_o) chk("cmd_accept_timeout", 0, 1);
    done_at_accept = done_cnt;
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_count", done_cnt, target);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int rb, pb, wb, da, k;
    logic [AW-1:0] exp_rd [6];
    exp_rd = '{16'h10, 16'h20, 16'h11, 16'h21, 16'h12, 16'h22};
    rst_n = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_instr_i = '0;
    cmd_addr_a_i = '0;
    cmd_addr_b_i = '0;
    cmd_addr_c_i = '0;
    cmd_len_i = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i = '0;
    pe_cmd_ready_i = 1'b0;
    pe_done_i = 1'b0;
    pe_result_i = '0;
    wr_ready_i = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 1; mem[8'h11] = 2; mem[8'h12] = 3;
    mem[8'h20] = 4; mem[8'h21] = 5; mem[8'h22] = 6;
    mem[8'h40] = 32'hFFFF_FFFF; mem[8'h41] = 1;
    mem[8'h50] = 1;             mem[8'h51] = 2;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk("rst_ctrl", {mem_req_valid_o, pe_cmd_valid_o, wr_valid_o, busy_o, done_o}, 5'b0);
    chk("rst_mem_addr", mem_req_addr_o, 0);
    chk("rst_wr", {wr_addr_o, wr_data_o}, 0);
    chk("rst_pe", {pe_cmd_o, pe_operand_a_o}, 0);
    #1 rst_n = 1'b1;

    // Basic dot product.
    rb = rd_log.size(); pb = pe_cmd_log.size(); wb = wr_data_log.size();
    send_cmd(16'h10, 16'h20, 16'h30, 8'd3, 16'hA5C3, da);
    wait_done(1, 300);
    chk("basic_reads", rd_log.size() - rb, 6);
    for (int i = 0; i < 6; i++)
      if (rb + i < rd_log.size()) chk($sformatf("basic_rd%0d", i), rd_log[rb + i], exp_rd[i]);
    chk("basic_issues", pe_cmd_log.size() - pb, 3);
    if (pe_cmd_log.size() > pb) chk("basic_pe_cmd", pe_cmd_log[pb], 16'hA5C3);
    chk("basic_writes", wr_data_log.size() - wb, 1);
    if (wr_data_log.size() > wb) begin
      chk("basic_wr_addr", wr_addr_log[wb], 16'h30);
      chk("basic_wr_data", wr_data_log[wb], 32);
    end

    // N = 0.
    rb = rd_log.size(); pb = pe_cmd_log.size(); wb = wr_data_log.size();
    send_cmd(16'h10, 16'h20, 16'h34, 8'd0, 16'h0101, da);
    wait_done(2, 100);
    chk("n0_reads", rd_log.size() - rb, 0);
    chk("n0_issues", pe_cmd_log.size() - pb, 0);
    chk("n0_writes", wr_data_log.size() - wb, 1);
    if (wr_data_log.size() > wb) chk("n0_wr", {wr_addr_log[wb], wr_data_log[wb]}, {16'h34, 32'd0});

    // Backpressure with slow memory.
    stall_en = 1'b1; mem_lat = 3; pe_lat = 2;
    rb = rd_log.size(); wb = wr_data_log.size();
    send_cmd(16'h10, 16'h20, 16'h35, 8'd3, 16'h3C3C, da);
    wait_done(3, 3000);
    stall_en = 1'b0; mem_lat = 1; pe_lat = 1;
    chk("bp_reads", rd_log.size() - rb, 6);
    chk("bp_writes", wr_data_log.size() - wb, 1);
    if (wr_data_log.size() > wb) chk("bp_wr", {wr_addr_log[wb], wr_data_log[wb]}, {16'h35, 32'd32});

    // Accumulator wrap: 0xFFFFFFFF + 2.
    wb = wr_data_log.size();
    send_cmd(16'h40, 16'h50, 16'h60, 8'd2, 16'h0F0F, da);
    wait_done(4, 300);
    if (wr_data_log.size() > wb) chk("ovf_wr", {wr_addr_log[wb], wr_data_log[wb]}, {16'h60, 32'd1});
    else chk("ovf_writes", wr_data_log.size() - wb, 1);

    // Reset while waiting on the PE.
    pe_lat = 6;
    pb = pe_cmd_log.size(); wb = wr_data_log.size();
    send_cmd(16'h10, 16'h20, 16'h36, 8'd3, 16'h7777, da);
    k = 0;
    while (pe_cmd_log.size() == pb && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid_issue_seen", pe_cmd_log.size() - pb, 1);
    @(negedge clk);
    chk("rstmid_busy_before", busy_o, 1'b1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_ctrl", {cmd_ready_o, mem_req_valid_o, pe_cmd_valid_o, wr_valid_o, busy_o, done_o}, 6'b100000);
    chk("rstmid_data", {wr_addr_o, wr_data_o, pe_operand_a_o}, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    pe_lat = 1;
    repeat (10) @(negedge clk);
    chk("rstmid_no_write", wr_data_log.size() - wb, 0);
    chk("rstmid_no_done", done_cnt, 4);
    send_cmd(16'h12, 16'h22, 16'h31, 8'd1, 16'h1234, da);
    wait_done(5, 300);
    if (wr_data_log.size() > wb) chk("rstmid_after_wr", {wr_addr_log[wb], wr_data_log[wb]}, {16'h31, 32'd18});
    else chk("rstmid_after_writes", wr_data_log.size() - wb, 1);

    // Second command presented while busy.
    wb = wr_data_log.size();
    send_cmd(16'h10, 16'h20, 16'h38, 8'd3, 16'h1111, da);
    send_cmd(16'h10, 16'h20, 16'h70, 8'd2, 16'h2222, da);
    chk("busy_accept_after_done", da, 6);
    wait_done(7, 300);
    chk("busy_writes", wr_data_log.size() - wb, 2);
    if (wr_data_log.size() >= wb + 2) begin
      chk("busy_wr1", {wr_addr_log[wb], wr_data_log[wb]}, {16'h38, 32'd32});
      chk("busy_wr2", {wr_addr_log[wb + 1], wr_data_log[wb + 1]}, {16'h70, 32'd14});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_dispatch_seq.md
Name: pe_dispatch_seq

Overview:
Upstream sequencer that feeds the PE array interface. It accepts one vector dot-product command: base addresses A, B and C, plus length N. For each element it fetches A[i] and B[i] over a single memory read port. It issues each pair to the PE interface, waits for pe_done, and accumulates the result. It writes the final sum to address C and pulses done_o. It sits between the control-unit decode and the PE array interface.

Parameters:
- DATA_WIDTH, nmcu_pkg::DATA_WIDTH, operand/result/accumulator width.
- ADDR_WIDTH, nmcu_pkg::ADDR_WIDTH, word address width.
- LEN_WIDTH, nmcu_pkg::LEN_WIDTH, element-count width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  high only in IDLE
- cmd_instr_i  in  $bits(instr_pkg::instruction_t)  instruction forwarded to PE
- cmd_addr_a_i / cmd_addr_b_i / cmd_addr_c_i  in  ADDR_WIDTH  base addresses
- cmd_len_i  in  LEN_WIDTH  element count N
- mem_req_valid_o  out  1  read request
- mem_req_ready_i  in  1  read accepted
- mem_req_addr_o  out  ADDR_WIDTH  read address
- mem_rsp_valid_i  in  1  read data valid
- mem_rsp_data_i  in  DATA_WIDTH  read data
- pe_cmd_valid_o  out  1  PE command valid
- pe_cmd_ready_i  in  1  PE ready
- pe_cmd_o  out  $bits(instruction_t)  latched instruction
- pe_operand_a_o / pe_operand_b_o  out  DATA_WIDTH  operands
- pe_done_i  in  1  PE result valid
- pe_result_i  in  DATA_WIDTH  PE result
- wr_valid_o  out  1  write-back valid
- wr_ready_i  in  1  write accepted
- wr_addr_o  out  ADDR_WIDTH  = latched C
- wr_data_o  out  DATA_WIDTH  accumulator
- busy_o  out  1  not IDLE
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs and registers are 0; state is IDLE; cmd_ready_o is 1 after reset.
- Reset mid-operation aborts immediately. No write is issued and no done_o pulse occurs.
- States: IDLE, REQ_A, RSP_A, REQ_B, RSP_B, ISSUE, WAIT_PE, WRITE, FIN.
- IDLE:
  - On cmd_valid_i&&cmd_ready_o, latch instr, A, B, C and N.
  - Clear the accumulator and the index i.
  - Go to WRITE if N==0, else REQ_A.
- REQ_A: mem_req_valid_o=1 with addr=A+i. Hold until mem_req_ready_i, then go to RSP_A.
- RSP_A: wait for mem_rsp_valid_i, capture operand A, go to REQ_B.
- REQ_B / RSP_B: same as REQ_A / RSP_A using B+i; capture operand B, go to ISSUE.
- Memory response latency is arbitrary (≥1 cycle). A response in the same cycle as the request is ignored. Only one request is outstanding at a time.
- ISSUE:
  - pe_cmd_valid_o=1 with registered operands and pe_cmd_o.
  - Operands and pe_cmd_o are held stable while valid and not ready.
  - On pe_cmd_ready_i, go to WAIT_PE.
- WAIT_PE:
  - On pe_done_i: acc <= acc + pe_result_i, truncated modulo 2^DATA_WIDTH; i <= i+1.
  - If i+1==N go to WRITE, else REQ_A.
  - PE latency ≥1 cycle. A pe_done_i seen in any other state is ignored.
- WRITE: wr_valid_o=1 with wr_addr_o=C and wr_data_o=acc. Hold until wr_ready_i, then go to FIN.
- FIN: done_o=1 for exactly one cycle, then IDLE.
- Addresses wrap modulo 2^ADDR_WIDTH.
- N at its maximum value (all ones) is legal; i is LEN_WIDTH bits and the compare uses i+1 at LEN_WIDTH+1 bits.
- Commands presented while busy are not accepted (cmd_ready_o=0) and not dropped; the source holds them.
- Throughput: minimum 6 cycles per element with zero-wait memory and a 1-cycle PE.

Decomposition:
- nmcu_pkg gains seq_state_e (the state enum).
- instruction_t is reused from instr_pkg.
- One sub-module is natural: pe_seq_accum, holding the accumulator register with clear, enable and wrap-add. Everything else stays in the FSM.

Test Plan:
- Basic dot product: A=[1,2,3] at 0x10, B=[4,5,6] at 0x20, C=0x30, N=3, 1-cycle memory and PE → reads at 0x10,0x20,0x11,0x21,0x12,0x22; three PE issues; one write of 32 to 0x30; one done_o pulse.
- N=0 → no memory reads and no PE issue; write 0 to C; done_o pulses.
- Backpressure: random stalls on mem_req_ready_i, pe_cmd_ready_i and wr_ready_i, with 3-cycle memory latency → address, operands and write data stay stable while stalled; result is still 32.
- Overflow: DATA_WIDTH=32, PE results 0xFFFFFFFF and 0x00000002 → written value is 0x00000001.
- Reset mid-operation: assert rst_n=0 in WAIT_PE → all outputs 0 and IDLE next cycle; no write; a new command runs cleanly afterwards.
- Busy command: a second cmd_valid_i during the first operation → not accepted until the first op's done_o; then accepted and executed with the second command's own addresses.
